// File: rtl/margin_scan_if.sv
// margin_scan_if: counter, score-BRAM and result signals of margin_scan_ctrl.
interface margin_scan_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 9
);
    logic                  i_start;
    logic                  o_cnt_en;
    logic [ADDR_WIDTH-1:0] i_cnt;
    logic                  o_mem_rd_en;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_result_valid;
    logic [IDX_WIDTH-1:0]  o_best_idx;
    logic [DATA_WIDTH-1:0] o_best_margin;

    modport slave (
        input  i_start, i_cnt, i_mem_rdata,
        output o_cnt_en, o_mem_rd_en, o_mem_addr, o_busy, o_done,
               o_result_valid, o_best_idx, o_best_margin
    );
    modport master (
        output i_start, i_cnt, i_mem_rdata,
        input  o_cnt_en, o_mem_rd_en, o_mem_addr, o_busy, o_done,
               o_result_valid, o_best_idx, o_best_margin
    );
endinterface

// File: rtl/margin_scan_ctrl.sv
// margin_scan_ctrl: streams per-class scores from BRAM via the address counter
// and reports the sample with the smallest top1-top2 margin.
module margin_scan_ctrl #(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CLASSES  = 10,
    parameter int NUM_SAMPLES  = 512,
    parameter int IDX_WIDTH    = 9,
    parameter int READ_LATENCY = 2
) (
    input logic          clk,
    input logic          rst_n,
    margin_scan_if.slave bus
);
    localparam int TOTAL = NUM_SAMPLES * NUM_CLASSES;
    localparam int CW    = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  r_state;
    logic                    r_cnt_en;
    logic                    r_done;
    logic                    r_result_valid;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic [CW-1:0]           r_class;
    logic [IDX_WIDTH-1:0]    r_sample;
    logic [IDX_WIDTH-1:0]    r_best_idx;
    logic [DATA_WIDTH-1:0]   r_top1;
    logic [DATA_WIDTH-1:0]   r_top2;
    logic [DATA_WIDTH-1:0]   r_best_margin;

    logic                  w_rd_en;
    logic                  w_valid;
    logic                  w_first;
    logic                  w_gt1;
    logic                  w_gt2;
    logic                  w_end;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_top1;
    logic [DATA_WIDTH-1:0] w_top2;
    logic [DATA_WIDTH-1:0] w_margin;

    assign w_rd_en  = r_state == S_RUN;
    assign w_valid  = r_rd_pipe[READ_LATENCY-1];
    assign w_first  = r_class == '0;
    assign w_gt1    = bus.i_mem_rdata > r_top1;
    assign w_gt2    = bus.i_mem_rdata > r_top2;
    // Ties with top1 fall through to top2, so equal leaders give margin 0.
    assign w_top1   = (w_first || w_gt1) ? bus.i_mem_rdata : r_top1;
    assign w_top2   = w_first ? '0 : w_gt1 ? r_top1 : w_gt2 ? bus.i_mem_rdata : r_top2;
    assign w_margin = w_top1 - w_top2;
    assign w_end    = w_valid && r_class == CW'(NUM_CLASSES - 1);
    assign w_last   = w_end && r_sample == IDX_WIDTH'(NUM_SAMPLES - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt_en       <= 1'b0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_rd_pipe      <= '0;
            r_class        <= '0;
            r_sample       <= '0;
            r_best_idx     <= '0;
            r_top1         <= '0;
            r_top2         <= '0;
            r_best_margin  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_rd_pipe <= (r_rd_pipe << 1) | READ_LATENCY'(w_rd_en);
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    r_state        <= S_RUN;
                    r_cnt_en       <= 1'b1;
                    r_result_valid <= 1'b0;
                    r_class        <= '0;
                    r_sample       <= '0;
                end
                S_RUN: if (bus.i_cnt == ADDR_WIDTH'(TOTAL - 1)) begin
                    r_state  <= S_DRAIN;
                    r_cnt_en <= 1'b0;
                end
                S_DRAIN: if (w_last) begin
                    r_state        <= S_IDLE;
                    r_done         <= 1'b1;
                    r_result_valid <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_valid) begin
                r_top1  <= w_top1;
                r_top2  <= w_top2;
                r_class <= w_end ? '0 : r_class + CW'(1);
                if (w_end) begin
                    r_sample <= r_sample + IDX_WIDTH'(1);
                    // Strict compare keeps the earliest sample on equal margins.
                    if (r_sample == '0 || w_margin < r_best_margin) begin
                        r_best_idx    <= r_sample;
                        r_best_margin <= w_margin;
                    end
                end
            end
        end
    end

    assign bus.o_cnt_en       = r_cnt_en;
    assign bus.o_mem_rd_en    = w_rd_en;
    assign bus.o_mem_addr     = w_rd_en ? bus.i_cnt : '0;
    assign bus.o_busy         = r_state != S_IDLE;
    assign bus.o_done         = r_done;
    assign bus.o_result_valid = r_result_valid;
    assign bus.o_best_idx     = r_best_idx;
    assign bus.o_best_margin  = r_best_margin;
endmodule

// File: tb/tb_margin_scan_ctrl.sv
// tb_margin_scan_ctrl: directed vectors on a 4x3 instance plus long scans on the
// default instance checked against a reference top-2 margin model.
module tb_margin_scan_ctrl;
    localparam int TOT_S = 12;
    localparam int NC_D  = 10;
    localparam int NS_D  = 512;
    localparam int TOT_D = 5120;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    margin_scan_if bs ();
    margin_scan_if bd ();

    margin_scan_ctrl #(.NUM_CLASSES(3), .NUM_SAMPLES(4)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
    margin_scan_ctrl dut_d (.clk(clk), .rst_n(rst_n), .bus(bd));

    logic [15:0] mem_s [16];
    logic [15:0] mem_d [8192];
    logic [15:0] rs1, rs2, rd1, rd2;

    // Address counters and two-cycle BRAMs
    always_ff @(posedge clk) begin
        bs.i_cnt <= bs.o_cnt_en ? bs.i_cnt + 13'd1 : 13'd0;
        bd.i_cnt <= bd.o_cnt_en ? bd.i_cnt + 13'd1 : 13'd0;
        if (bs.o_mem_rd_en) rs1 <= mem_s[bs.o_mem_addr[3:0]];
        if (bd.o_mem_rd_en) rd1 <= mem_d[bd.o_mem_addr];
        rs2 <= rs1;
        rd2 <= rd1;
    end
    assign bs.i_mem_rdata = rs2;
    assign bd.i_mem_rdata = rd2;

    typedef struct {
        logic [0:11][15:0] sc;
        int                idx;
        int                margin;
    } vec_t;
    vec_t vecs [6];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_s(input int n);
        int dcyc = -1;
        int hits [16];
        int oob = 0;
        int once = 0;
        foreach (hits[i]) hits[i] = 0;
        for (int i = 0; i < TOT_S; i++) mem_s[i] = vecs[n].sc[i];
        @(negedge clk) bs.i_start = 1'b1;
        @(posedge clk);
        #1 bs.i_start = 1'b0;
        for (int k = 0; k < 40 && dcyc < 0; k++) begin
            @(negedge clk);
            if (k == 0) chk($sformatf("v%0d_rv_clear", n), bs.o_result_valid, 0);
            if (bs.o_mem_rd_en) begin
                if (bs.o_mem_addr < 13'(TOT_S)) hits[int'(bs.o_mem_addr)]++;
                else oob++;
            end
            if (bs.o_done) dcyc = k;
        end
        for (int i = 0; i < TOT_S; i++) if (hits[i] == 1) once++;
        chk($sformatf("v%0d_done_cycle", n), dcyc, 14);
        chk($sformatf("v%0d_best_idx", n), bs.o_best_idx, vecs[n].idx);
        chk($sformatf("v%0d_best_margin", n), bs.o_best_margin, vecs[n].margin);
        chk($sformatf("v%0d_result_valid", n), bs.o_result_valid, 1);
        chk($sformatf("v%0d_addr_once", n), once, TOT_S);
        chk($sformatf("v%0d_addr_oob", n), oob, 0);
    endtask

    task automatic scan_d(input int pa, input int pb, input bit restart,
                          output int dcyc, output int ndone, output int nrd, output int nbad);
        dcyc = -1; ndone = 0; nrd = 0; nbad = 0;
        @(negedge clk) bd.i_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < TOT_D + 10; k++) begin
            @(negedge clk);
            bd.i_start = (k == pa || k == pb);
            if (bd.o_mem_rd_en) begin
                nrd++;
                if (bd.o_mem_addr == 13'(TOT_D)) nbad++;
            end
            if (bd.o_done) begin
                ndone++;
                if (dcyc < 0) dcyc = k;
                if (restart) begin
                    bd.i_start = 1'b1;
                    break;
                end
            end
        end
    endtask

    function automatic void model_d(output int bi, output int bm);
        bi = 0; bm = 0;
        for (int s = 0; s < NS_D; s++) begin
            int mx = -1, mi = 0, sec = -1;
            for (int c = 0; c < NC_D; c++)
                if (int'(mem_d[s*NC_D+c]) > mx) begin mx = int'(mem_d[s*NC_D+c]); mi = c; end
            for (int c = 0; c < NC_D; c++)
                if (c != mi && int'(mem_d[s*NC_D+c]) > sec) sec = int'(mem_d[s*NC_D+c]);
            if (s == 0 || mx - sec < bm) begin bi = s; bm = mx - sec; end
        end
    endfunction

    task automatic check_d(input string tag, input int dcyc, input int ndone);
        int bi, bm;
        model_d(bi, bm);
        chk({tag, "_done_cycle"}, dcyc, 5122);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_best_idx"}, bd.o_best_idx, bi);
        chk({tag, "_best_margin"}, bd.o_best_margin, bm);
    endtask

    initial begin
        int dcyc, ndone, nrd, nbad, seen;
        vecs[0].sc = {16'd10, 16'd5, 16'd1, 16'd7, 16'd7, 16'd0, 16'd9, 16'd1, 16'd8, 16'd0, 16'd3, 16'd3};
        vecs[0].idx = 1; vecs[0].margin = 0;
        vecs[1].sc = {4{16'hFFFF, 16'd0, 16'd0}};
        vecs[1].idx = 0; vecs[1].margin = 'hFFFF;
        vecs[2].sc = {16'd100, 16'd0, 16'd50, 16'd20, 16'd30, 16'd0, 16'd5, 16'd9, 16'd7, 16'd1, 16'd1, 16'd1};
        vecs[2].idx = 3; vecs[2].margin = 0;
        vecs[3].sc = {16'd1, 16'd2, 16'd3, 16'd50, 16'd10, 16'd60, 16'd0, 16'd0, 16'd1, 16'd4, 16'd8, 16'd6};
        vecs[3].idx = 0; vecs[3].margin = 1;
        vecs[4].sc = {16'd8, 16'd8, 16'd8, 16'd0, 16'd0, 16'd0, 16'd5, 16'd1, 16'd2, 16'd3, 16'd9, 16'd4};
        vecs[4].idx = 0; vecs[4].margin = 0;
        vecs[5].sc = {16'd50, 16'd4, 16'd0, 16'd10, 16'd0, 16'd0, 16'd30, 16'd0, 16'd10, 16'd40, 16'd0, 16'd25};
        vecs[5].idx = 1; vecs[5].margin = 10;

        bs.i_start = 1'b1;
        bd.i_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_busy", bs.o_busy, 0);
        chk("rst_s_done", bs.o_done, 0);
        chk("rst_s_cnt_en", bs.o_cnt_en, 0);
        chk("rst_s_rv", bs.o_result_valid, 0);
        chk("rst_s_idx", bs.o_best_idx, 0);
        chk("rst_s_margin", bs.o_best_margin, 0);
        chk("rst_d_busy", bd.o_busy, 0);
        chk("rst_d_cnt_en", bd.o_cnt_en, 0);
        chk("rst_d_rd_en", bd.o_mem_rd_en, 0);
        chk("rst_d_rv", bd.o_result_valid, 0);
        rst_n = 1'b1;
        bs.i_start = 1'b0;
        bd.i_start = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", bs.o_busy, 0);

        for (int n = 0; n < 6; n++) run_s(n);

        for (int i = 0; i < TOT_D; i++) mem_d[i] = 16'($urandom_range(0, 65535));
        scan_d(3, 100, 1'b0, dcyc, ndone, nrd, nbad);
        check_d("d1", dcyc, ndone);
        chk("d1_rd_cycles", nrd, TOT_D);
        chk("d1_addr_total_read", nbad, 0);

        for (int i = 0; i < TOT_D; i++) mem_d[i] = 16'($urandom_range(0, 65535));
        scan_d(-1, -1, 1'b1, dcyc, ndone, nrd, nbad);
        check_d("d2", dcyc, ndone);
        @(negedge clk);
        chk("restart_busy", bd.o_busy, 1);
        bd.i_start = 1'b0;

        repeat (50) @(negedge clk);
        chk("mid_cnt_en_before", bd.o_cnt_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_cnt_en", bd.o_cnt_en, 0);
        chk("mid_busy", bd.o_busy, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bd.o_done || bd.o_busy) seen++;
        end
        chk("mid_no_done", seen, 0);

        for (int i = 0; i < TOT_D; i++) mem_d[i] = 16'($urandom_range(0, 15));
        scan_d(-1, -1, 1'b0, dcyc, ndone, nrd, nbad);
        check_d("d3", dcyc, ndone);
        chk("d3_rd_cycles", nrd, TOT_D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/margin_scan_ctrl.md
Name: margin_scan_ctrl

Overview:
- Margin-sampling scan engine; sits directly downstream of the address counter and drives that counter's enable.
- Streams per-class scores for every sample out of the score BRAM, using the counter's address sequence.
- Tracks the top-2 scores per sample and reports the sample with the smallest (top1 - top2) margin.

Parameters:
- ADDR_WIDTH, 13, width of counter value and BRAM address.
- DATA_WIDTH, 16, unsigned score width.
- NUM_CLASSES, 10, scores per sample (>=2).
- NUM_SAMPLES, 512, samples per scan.
- IDX_WIDTH, 9, sample index width (2^IDX_WIDTH >= NUM_SAMPLES).
- READ_LATENCY, 2, BRAM cycles from address to rdata (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  scan request; honoured only in IDLE.
- cnt_en  out  1  enable to address counter (counter clears when low, +1 per cycle when high).
- cnt  in  ADDR_WIDTH  current counter value.
- mem_rd_en  out  1  BRAM read enable.
- mem_addr  out  ADDR_WIDTH  BRAM read address.
- mem_rdata  in  DATA_WIDTH  BRAM read data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the result is final.
- result_valid  out  1  result registers hold a completed scan.
- best_idx  out  IDX_WIDTH  sample with the minimum margin.
- best_margin  out  DATA_WIDTH  that minimum margin.

Behaviour:
- Interface reset: rst_n is synchronous and active-low; clock is clk.
- Reset values: all outputs 0; state IDLE; internal registers cleared.
- Reset mid-scan: the scan is abandoned, no done pulse follows, and cnt_en drops immediately, which clears the counter.
- Memory layout: score(s, c) is at address s*NUM_CLASSES + c. TOTAL = NUM_SAMPLES*NUM_CLASSES, which must be <= 2^ADDR_WIDTH.
- State IDLE: cnt_en = 0. On start, clear result_valid and go to RUN.
- State RUN: cnt_en = 1, mem_rd_en = 1, mem_addr = cnt (combinational).
  - The counter starts at 0, so addresses 0..TOTAL-1 are issued one per cycle.
  - When cnt == TOTAL-1, go to DRAIN at the next edge.
  - Address TOTAL, which the counter reaches one cycle later, is never read (mem_rd_en = 0).
- State DRAIN: cnt_en = 0. Wait for the outstanding reads to return, then go to IDLE with done.
- Read tracking:
  - A READ_LATENCY-deep shift register carries mem_rd_en.
  - Its tap qualifies mem_rdata as valid score d.
  - A class counter (0..NUM_CLASSES-1) and a sample counter advance on each valid score.
- Top-2 update per valid d (unsigned compare):
  - Class 0: top1 = d, top2 = 0.
  - Other classes, d > top1: top2 = top1, top1 = d.
  - Other classes, else if d > top2: top2 = d.
  - Ties with top1 land in top2, giving margin 0.
- End of sample (class NUM_CLASSES-1): margin = new top1 - new top2, computed combinationally from the updated values; never negative.
  - Sample 0: best_margin and best_idx load unconditionally.
  - Later samples: update only if margin < best_margin (strict), so the earliest index wins ties.
- Completion: on the edge that processes the last score of the last sample:
  - best registers update;
  - done = 1 for exactly one cycle;
  - result_valid = 1, held until the next accepted start;
  - state = IDLE.
- Latency: done is high in cycle TOTAL + READ_LATENCY, counting the edge that samples start as edge 0. Default: 5122.
- start while busy: ignored.
- start in the done cycle: accepted, because the state is already IDLE.
- best_idx and best_margin hold their values between scans.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles with start = 1 -> done, busy, cnt_en, result_valid, best_idx and best_margin all 0; state stays IDLE.
- Small config, ties: NUM_SAMPLES=4, NUM_CLASSES=3, READ_LATENCY=2. Scores s0 {10,5,1}, s1 {7,7,0}, s2 {9,1,8}, s3 {0,3,3} -> best_idx = 1, best_margin = 0. done in cycle 14; mem_addr is 0..11 exactly once each.
- All margins maximal: every sample is {FFFF, 0, ...} -> best_margin = FFFF, best_idx = 0 (unconditional load of sample 0).
- start pulses at cycles 3 and 100 during a default scan -> both ignored. done appears once, at cycle 5122. A start in the done cycle launches a new scan and busy is high in the next cycle.
- Reset mid-run: drop rst_n at cycle 50 of a scan -> next cycle cnt_en = 0, busy = 0; no done afterwards; a fresh scan completes correctly.
- Default config, random scores vs reference model -> best_idx and best_margin match. mem_rd_en is high for exactly 5120 cycles and address 5120 is never read.
